// File: rtl/rom_stream_reader_pkg.sv
// Shared constants and state type for the ROM stream reader.
package rom_stream_reader_pkg;

  localparam int unsigned DEF_READ_ADDR_WIDTH = 8;
  localparam int unsigned DEF_WIDTH           = 8;
  localparam int unsigned DEF_LEN_WIDTH       = 8;

  // Common to every ROM user in the JESD TX path.
  localparam int unsigned ROM_RD_LATENCY = 1;
  localparam int unsigned BUF_DEPTH      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rom_stream_reader_stream_skid_buf.sv
// Two-entry FIFO between the ROM return path and the downstream valid/ready stream.
module stream_skid_buf #(
  parameter int unsigned DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [1:0]    o_count
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          w_pop;

  assign w_pop   = (r_count != 2'd0) && i_ready;
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // The producer only pushes when it holds a free slot, so no push is ever refused.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= !r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= !r_rd_ptr;
      end
      r_count <= r_count + 2'(i_push) - 2'(w_pop);
    end
  end

endmodule

// File: rtl/rom_stream_reader.sv
// Fetches a run of words from a 1-cycle-latency ROM and presents them as a
// valid/ready stream with a last marker on the final word.
module rom_stream_reader
  import rom_stream_reader_pkg::*;
#(
  parameter int unsigned READ_ADDR_WIDTH = DEF_READ_ADDR_WIDTH,
  parameter int unsigned WIDTH           = DEF_WIDTH,
  parameter int unsigned LEN_WIDTH       = DEF_LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [READ_ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]       i_len,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [READ_ADDR_WIDTH-1:0] o_rom_addr,
  output logic                       o_rom_rd_en,
  input  logic [WIDTH-1:0]           i_rom_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_last
);

  localparam int unsigned CNT_W = LEN_WIDTH + 1;
  localparam int unsigned BUF_W = WIDTH + 1;

  state_t                      r_state;
  logic [READ_ADDR_WIDTH-1:0]  r_base;
  logic [CNT_W-1:0]            r_len;
  logic [CNT_W-1:0]            r_issued;
  logic [CNT_W-1:0]            r_accepted;
  logic [ROM_RD_LATENCY-1:0]   r_rd_pipe;
  logic [ROM_RD_LATENCY-1:0]   r_last_pipe;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_rst_q;

  logic                        w_rd_en;
  logic                        w_pop;
  logic                        w_issue_last;
  logic                        w_buf_valid;
  logic [BUF_W-1:0]            w_buf_data;
  logic [1:0]                  w_buf_count;
  logic [2:0]                  w_credit_used;

  // A word leaving the buffer this cycle frees its slot for a new read.
  assign w_pop         = w_buf_valid && i_ready;
  assign w_credit_used = 3'(w_buf_count) + 3'($countones(r_rd_pipe)) - 3'(w_pop);
  assign w_rd_en       = (r_state == ST_READ) && (r_issued < r_len) &&
                         (w_credit_used < 3'(BUF_DEPTH));
  assign w_issue_last  = (r_issued + CNT_W'(1)) == r_len;

  assign o_rom_rd_en = w_rd_en;
  assign o_rom_addr  = r_base + READ_ADDR_WIDTH'(r_issued);
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_valid     = w_buf_valid;
  assign o_data      = w_buf_data[WIDTH-1:0];
  assign o_last      = w_buf_data[WIDTH];

  stream_skid_buf #(
    .DW (BUF_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_rd_pipe[ROM_RD_LATENCY-1]),
    .i_data  ({r_last_pipe[ROM_RD_LATENCY-1], i_rom_data}),
    .o_valid (w_buf_valid),
    .i_ready (i_ready),
    .o_data  (w_buf_data),
    .o_count (w_buf_count)
  );

  // Transfer sequencing, counters and read-return tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_len       <= '0;
      r_issued    <= '0;
      r_accepted  <= '0;
      r_rd_pipe   <= '0;
      r_last_pipe <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rst_q     <= 1'b1;
    end else begin
      r_rst_q        <= 1'b0;
      r_done         <= 1'b0;
      r_rd_pipe[0]   <= w_rd_en;
      r_last_pipe[0] <= w_rd_en && w_issue_last;
      for (int k = 1; k < int'(ROM_RD_LATENCY); k++) begin
        r_rd_pipe[k]   <= r_rd_pipe[k-1];
        r_last_pipe[k] <= r_last_pipe[k-1];
      end
      if (w_rd_en) begin
        r_issued <= r_issued + CNT_W'(1);
      end
      if (w_pop) begin
        r_accepted <= r_accepted + CNT_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (i_start && !r_rst_q) begin
            r_base     <= i_base_addr;
            r_len      <= {1'b0, i_len};
            r_issued   <= '0;
            r_accepted <= '0;
            r_busy     <= 1'b1;
            if (i_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (r_issued == r_len) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && ((r_accepted + CNT_W'(1)) == r_len)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Randomised and directed bench for rom_stream_reader against a word-list reference model.
module tb_rom_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_base_addr = '0;
  logic [7:0] i_len = '0;
  logic       i_ready = 1'b1;
  logic [7:0] rom_q = '0;
  logic       o_busy, o_done, o_rom_rd_en, o_valid, o_last;
  logic [7:0] o_rom_addr, o_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] obs_data[$];
  logic       obs_last[$];
  int         obs_hs_cyc[$];
  logic [7:0] obs_addr[$];
  int         obs_rd_cyc[$];
  int done_cyc, done_cnt, max_out, stall_viol, first_valid_cyc, timed_out, rd_before11;

  rom_stream_reader dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_len       (i_len),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rom_addr  (o_rom_addr),
    .o_rom_rd_en (o_rom_rd_en),
    .i_rom_data  (rom_q),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_last      (o_last)
  );

  always #5 clk = ~clk;

  // ROM: DEPTH=64, data[a]=a+0x10, zero beyond the populated range.
  always @(posedge clk) begin
    if (o_rom_rd_en) rom_q <= (o_rom_addr < 8'd64) ? o_rom_addr + 8'h10 : 8'h00;
  end

  // Expected word i of a transfer from base: address wraps mod 256.
  function automatic logic [7:0] model_word(input logic [7:0] base, input int i);
    logic [7:0] a;
    a = base + 8'(i);
    return (a < 8'd64) ? a + 8'h10 : 8'h00;
  endfunction

  // Runs one transfer; mode 0 ready=1, 1 toggling, 2 low through cycle 10, 3 random.
  task automatic run_xfer(input logic [7:0] base, input logic [7:0] len, input int mode, input int spam);
    int issued_n, acc_n;
    logic pv, pr, pl;
    logic [7:0] pd;
    obs_data.delete(); obs_last.delete(); obs_hs_cyc.delete();
    obs_addr.delete(); obs_rd_cyc.delete();
    done_cyc = -1; done_cnt = 0; max_out = 0; stall_viol = 0;
    first_valid_cyc = -1; timed_out = 0; rd_before11 = 0;
    issued_n = 0; acc_n = 0; pv = 0; pr = 0; pl = 0; pd = '0;
    @(negedge clk);
    i_start = 1'b1; i_base_addr = base; i_len = len;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        i_start = (spam != 0) && (cyc <= 3);
        if (spam != 0) begin i_base_addr = 8'h30; i_len = 8'd5; end
      end
      case (mode)
        0:       i_ready = 1'b1;
        1:       i_ready = (cyc % 2) == 0;
        2:       i_ready = cyc > 10;
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (issued_n - acc_n > max_out) max_out = issued_n - acc_n;
      if (pv && !pr && (!o_valid || o_data !== pd || o_last !== pl)) stall_viol++;
      if (o_rom_rd_en) begin
        obs_addr.push_back(o_rom_addr); obs_rd_cyc.push_back(cyc);
        issued_n++;
        if (cyc <= 10) rd_before11++;
      end
      if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (o_valid && i_ready) begin
        obs_data.push_back(o_data); obs_last.push_back(o_last); obs_hs_cyc.push_back(cyc);
        acc_n++;
      end
      if (o_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      pv = o_valid; pr = i_ready; pd = o_data; pl = o_last;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    if (done_cyc < 0) timed_out = 1;
    i_start = 1'b0; i_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({o_busy, o_done, o_rom_addr, o_rom_rd_en, o_data, o_valid, o_last} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b addr=%h rd=%0b data=%h valid=%0b last=%0b, want all 0",
               o_busy, o_done, o_rom_addr, o_rom_rd_en, o_data, o_valid, o_last);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int bad;
    run_xfer(8'd4, 8'd3, 0, 0);
    checks++;
    if (timed_out != 0) begin errors++; $display("FAIL basic_timeout: no o_done within bound"); end
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (i >= obs_addr.size() || obs_addr[i] !== 8'(4 + i) || obs_rd_cyc[i] != obs_rd_cyc[0] + i) bad++;
    checks++;
    if (bad != 0 || obs_addr.size() != 3) begin
      errors++; $display("FAIL basic_addr: %0d bad reads of %0d, want 3 consecutive 04..06", bad, obs_addr.size());
    end
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (i >= obs_data.size() || obs_data[i] !== model_word(8'd4, i) || obs_last[i] !== (i == 2) ||
          obs_hs_cyc[i] != obs_hs_cyc[0] + i) bad++;
    checks++;
    if (bad != 0 || obs_data.size() != 3) begin
      errors++; $display("FAIL basic_stream: %0d bad words of %0d, want 14,15,16 back to back", bad, obs_data.size());
    end
    checks++;
    if (obs_rd_cyc.size() == 0 || first_valid_cyc != obs_rd_cyc[0] + 2) begin
      errors++; $display("FAIL basic_latency: first valid cycle %0d, want 2 after first read", first_valid_cyc);
    end
    checks++;
    if (obs_hs_cyc.size() != 3 || done_cyc != obs_hs_cyc[2] + 1 || done_cnt != 1) begin
      errors++; $display("FAIL basic_done: done cycle %0d count %0d, want 1 pulse after last handshake", done_cyc, done_cnt);
    end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL basic_idle: busy=%0b want 0", o_busy); end
  endtask

  task automatic test_toggle();
    int bad;
    run_xfer(8'd0, 8'd8, 1, 0);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (i >= obs_data.size() || obs_data[i] !== model_word(8'd0, i) || obs_last[i] !== (i == 7)) bad++;
    checks++;
    if (bad != 0 || obs_data.size() != 8 || timed_out != 0) begin
      errors++; $display("FAIL toggle_stream: %0d bad words, got %0d words want 8", bad, obs_data.size());
    end
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL toggle_stable: %0d stall violations, want 0", stall_viol); end
    checks++;
    if (max_out > 2) begin errors++; $display("FAIL toggle_credit: outstanding peak %0d, want <=2", max_out); end
  endtask

  task automatic test_empty();
    run_xfer(8'd9, 8'd0, 0, 0);
    checks++;
    if (obs_addr.size() != 0 || first_valid_cyc != -1) begin
      errors++; $display("FAIL empty_activity: reads %0d first valid %0d, want 0 and none", obs_addr.size(), first_valid_cyc);
    end
    checks++;
    if (done_cyc != 1 || done_cnt != 1) begin
      errors++; $display("FAIL empty_done: done cycle %0d count %0d, want cycle 1 count 1", done_cyc, done_cnt);
    end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL empty_idle: busy=%0b want 0", o_busy); end
  endtask

  task automatic test_wrap();
    int bad;
    run_xfer(8'hFE, 8'd4, 0, 0);
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= obs_addr.size() || obs_addr[i] !== 8'hFE + 8'(i)) bad++;
    checks++;
    if (bad != 0 || obs_addr.size() != 4) begin
      errors++; $display("FAIL wrap_addr: %0d bad of %0d reads, want FE,FF,00,01", bad, obs_addr.size());
    end
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= obs_data.size() || obs_data[i] !== model_word(8'hFE, i) || obs_last[i] !== (i == 3)) bad++;
    checks++;
    if (bad != 0 || obs_data.size() != 4) begin
      errors++; $display("FAIL wrap_stream: %0d bad of %0d words, want 00,00,10,11", bad, obs_data.size());
    end
  endtask

  task automatic test_stall();
    int bad;
    run_xfer(8'd2, 8'd5, 2, 0);
    checks++;
    if (rd_before11 != 2) begin
      errors++; $display("FAIL stall_reads: %0d reads while stalled, want 2", rd_before11);
    end
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (i >= obs_data.size() || obs_data[i] !== model_word(8'd2, i) || obs_last[i] !== (i == 4)) bad++;
    checks++;
    if (bad != 0 || obs_data.size() != 5 || stall_viol != 0 || timed_out != 0) begin
      errors++; $display("FAIL stall_stream: %0d bad of %0d words, %0d stall violations, want 12..16 clean",
                         bad, obs_data.size(), stall_viol);
    end
  endtask

  task automatic test_start_ignored();
    int bad;
    run_xfer(8'h20, 8'd5, 0, 1);
    bad = 0;
    for (int i = 0; i < 5; i++)
      if (i >= obs_data.size() || obs_data[i] !== model_word(8'h20, i)) bad++;
    checks++;
    if (bad != 0 || obs_data.size() != 5 || done_cnt != 1) begin
      errors++; $display("FAIL busy_start: %0d bad of %0d words, done count %0d, want 30..34 once",
                         bad, obs_data.size(), done_cnt);
    end
  endtask

  task automatic test_abort();
    int dn;
    @(negedge clk);
    i_start = 1'b1; i_base_addr = 8'd0; i_len = 8'd6; i_ready = 1'b1;
    @(negedge clk); i_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_busy !== 1'b1) begin errors++; $display("FAIL abort_busy: busy=%0b before reset, want 1", o_busy); end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if ({o_busy, o_done, o_rom_addr, o_rom_rd_en, o_data, o_valid, o_last} !== 21'd0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%0b done=%0b addr=%h rd=%0b data=%h valid=%0b last=%0b, want all 0",
               o_busy, o_done, o_rom_addr, o_rom_rd_en, o_data, o_valid, o_last);
    end
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (o_done || o_valid) dn++;
    end
    checks++;
    if (dn != 0) begin errors++; $display("FAIL abort_quiet: %0d cycles with done/valid after abort, want 0", dn); end
    run_xfer(8'd0, 8'd2, 0, 0);
    checks++;
    if (obs_data.size() != 2 || obs_data[0] !== 8'h10 || obs_data[1] !== 8'h11 ||
        obs_last[0] !== 1'b0 || obs_last[1] !== 1'b1 || done_cnt != 1) begin
      errors++; $display("FAIL abort_restart: got %0d words, done count %0d, want 10,11 then done", obs_data.size(), done_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] base, len;
    int bad;
    for (int t = 0; t < 8; t++) begin
      base = 8'($urandom_range(0, 255));
      len  = 8'($urandom_range(0, 12));
      run_xfer(base, len, 3, 0);
      bad = 0;
      for (int i = 0; i < int'(len); i++)
        if (i >= obs_data.size() || i >= obs_addr.size() || obs_data[i] !== model_word(base, i) ||
            obs_addr[i] !== base + 8'(i) || obs_last[i] !== (i == int'(len) - 1)) bad++;
      checks++;
      if (bad != 0 || obs_data.size() != int'(len) || obs_addr.size() != int'(len) || timed_out != 0) begin
        errors++; $display("FAIL random_stream[%0d]: base=%h len=%0d bad=%0d words=%0d reads=%0d",
                           t, base, len, bad, obs_data.size(), obs_addr.size());
      end
      checks++;
      if (stall_viol != 0 || max_out > 2 || done_cnt != 1 ||
          (len != 0 && obs_hs_cyc.size() != 0 && done_cyc != obs_hs_cyc[obs_hs_cyc.size()-1] + 1) ||
          (len == 0 && done_cyc != 1)) begin
        errors++; $display("FAIL random_protocol[%0d]: stalls=%0d peak=%0d done_cnt=%0d done_cyc=%0d",
                           t, stall_viol, max_out, done_cnt, done_cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_empty();
    test_wrap();
    test_stall();
    test_start_ignored();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
